io_read_port_fifo: RTL



---
 rtl/io_read_port_fifo.sv | 105 ++++++++++
 1 files changed

// File: rtl/io_read_port_fifo.sv
// Show-ahead FIFO that feeds one CPU I/O read port from a valid/ready producer.
// Head word, empty flag and ready are all held in registers, so no combinational path crosses the FIFO.
module io_read_port_fifo #(
   parameter int unsigned WORD_WIDTH = 36,
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned ADDR_WIDTH = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [WORD_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [WORD_WIDTH-1:0] io_in,
   output logic                  io_in_EF,
   input  logic                  io_rden,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  underflow
);

   localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

   logic [WORD_WIDTH-1:0] mem_q [DEPTH];

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_WIDTH-1:0]  count_q, count_d;
   logic                  empty_q, empty_d;
   logic                  full_q, full_d;
   logic [WORD_WIDTH-1:0] head_q, head_d;
   logic                  underflow_q, underflow_d;

   logic push_c;
   logic pop_c;

   assign push_c = in_valid & ~full_q;
   assign pop_c  = io_rden & ~empty_q;

   assign in_ready  = ~full_q;
   assign io_in_EF  = empty_q;
   assign io_in     = head_q;
   assign count     = count_q;
   assign underflow = underflow_q;

   // Next-state: pointers, occupancy, flags and the head word as seen after this edge.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      underflow_d = underflow_q | (io_rden & empty_q);

      if (push_c) begin
         wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      end
      if (pop_c) begin
         rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      end

      case ({push_c, pop_c})
         2'b10:   count_d = count_q + CNT_WIDTH'(1);
         2'b01:   count_d = count_q - CNT_WIDTH'(1);
         default: count_d = count_q;
      endcase

      empty_d = (count_d == CNT_WIDTH'(0));
      full_d  = (count_d == CNT_WIDTH'(DEPTH));

      // The word written this edge bypasses storage when it becomes the new head.
      if (empty_d) begin
         head_d = '0;
      end else if (push_c && (wr_ptr_q == rd_ptr_d)) begin
         head_d = in_data;
      end else begin
         head_d = mem_q[rd_ptr_d];
      end
   end

   // Control and output registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         empty_q     <= 1'b1;
         full_q      <= 1'b0;
         head_q      <= '0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         empty_q     <= empty_d;
         full_q      <= full_d;
         head_q      <= head_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage array is deliberately left unreset.
   always_ff @(posedge clock) begin
      if (push_c) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

endmodule
